// File: rtl/sweep_max_counter.sv
// Sweep position counter with per-sweep peak tracking and return-to-peak countdown.
// Optional build macro SWEEP_MAX_HYST_EN: a new peak must beat the current one by HYST.
module sweep_max_counter #(
  parameter int SWEEP_STEPS = 16,
  parameter int STEP_DIV    = 4,
  parameter int LIGHT_W     = 10,
  parameter int POS_W       = 4,
  parameter int HYST        = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               HS,
  input  logic               VS,
  input  logic               MC,
  input  logic               CNT_RST,
  input  logic [LIGHT_W-1:0] LIGHT,
  output logic               CNT_L,
  output logic               CNT_RU,
  output logic               CNT_D,
  output logic [POS_W-1:0]   MAX_POS,
  output logic [LIGHT_W-1:0] MAX_VAL
);

  localparam int               PS_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(SWEEP_STEPS - 1);

  if (SWEEP_STEPS < 2 || STEP_DIV < 1 || (2 ** POS_W) < SWEEP_STEPS || HYST < 0) begin : g_bad_cfg
    $error("sweep_max_counter: invalid parameter set");
  end

  // Peak-acceptance test; the hysteresis sum is one bit wider so it cannot wrap.
  function automatic logic beats(input logic [LIGHT_W-1:0] sample,
                                 input logic [LIGHT_W-1:0] best);
`ifdef SWEEP_MAX_HYST_EN
    logic [LIGHT_W:0] thresh;
    thresh = {1'b0, best} + (LIGHT_W + 1)'(HYST);
    return {1'b0, sample} > thresh;
`else
    return sample > best;
`endif
  endfunction

  logic [PS_W-1:0]    presc;
  logic [POS_W-1:0]   pos;
  logic [POS_W-1:0]   cur_pos;
  logic [LIGHT_W-1:0] cur_max;
  logic [POS_W-1:0]   ret;

  logic               active;
  logic               tick;
  logic               sweep_h;
  logic               sweep_v;
  logic               ret_step;
  logic               take;
  logic               at_end;
  logic [LIGHT_W-1:0] win_val;
  logic [POS_W-1:0]   win_pos;

  // Enable priority HS > VS > MC: a done HS still masks VS and MC.
  assign active   = HS | VS | MC;
  assign tick     = active && (presc == PS_LAST);
  assign sweep_h  = HS && CNT_L;
  assign sweep_v  = !HS && VS && CNT_D;
  assign ret_step = !HS && !VS && MC && (ret != '0);

  assign take    = (pos == '0) || beats(LIGHT, cur_max);
  assign win_val = take ? LIGHT : cur_max;
  assign win_pos = take ? pos : cur_pos;
  assign at_end  = (pos == POS_LAST);

  assign CNT_RU = (ret != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc   <= '0;
      pos     <= '0;
      cur_pos <= '0;
      cur_max <= '0;
      ret     <= '0;
      CNT_L   <= 1'b1;
      CNT_D   <= 1'b1;
      MAX_POS <= '0;
      MAX_VAL <= '0;
    end else if (CNT_RST) begin
      presc   <= '0;
      pos     <= '0;
      cur_pos <= '0;
      cur_max <= '0;
      ret     <= '0;
      CNT_L   <= 1'b1;
      CNT_D   <= 1'b1;
      MAX_POS <= '0;
      MAX_VAL <= '0;
    end else begin
      if (!active || tick) presc <= '0;
      else                 presc <= presc + 1'b1;

      if (tick && (sweep_h || sweep_v)) begin
        cur_max <= win_val;
        cur_pos <= win_pos;
        if (at_end) begin
          pos     <= '0;
          MAX_POS <= win_pos;
          MAX_VAL <= win_val;
          ret     <= POS_LAST - win_pos;
          if (sweep_h) CNT_L <= 1'b0;
          else         CNT_D <= 1'b0;
        end else begin
          pos <= pos + 1'b1;
        end
      end else if (tick && ret_step) begin
        ret <= ret - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sweep_max_counter.sv
// Scoreboard bench for sweep_max_counter: expectations are queued when a sweep or
// return is launched and compared when the DUT signals completion.
module tb_sweep_max_counter;

  localparam int SWEEP_STEPS = 8;
  localparam int STEP_DIV    = 4;
  localparam int LIGHT_W     = 10;
  localparam int POS_W       = 3;
  localparam int HYST        = 2;
  localparam int BOUND       = 100;
`ifdef SWEEP_MAX_HYST_EN
  localparam int MARGIN = HYST;
`else
  localparam int MARGIN = 0;
`endif

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               HS = 1'b0, VS = 1'b0, MC = 1'b0, CNT_RST = 1'b0;
  logic [LIGHT_W-1:0] LIGHT = '0;
  logic               CNT_L, CNT_RU, CNT_D;
  logic [POS_W-1:0]   MAX_POS;
  logic [LIGHT_W-1:0] MAX_VAL;

  sweep_max_counter #(
    .SWEEP_STEPS(SWEEP_STEPS), .STEP_DIV(STEP_DIV), .LIGHT_W(LIGHT_W),
    .POS_W(POS_W), .HYST(HYST)
  ) dut (
    .CLK(CLK), .RST(RST), .HS(HS), .VS(VS), .MC(MC), .CNT_RST(CNT_RST),
    .LIGHT(LIGHT), .CNT_L(CNT_L), .CNT_RU(CNT_RU), .CNT_D(CNT_D),
    .MAX_POS(MAX_POS), .MAX_VAL(MAX_VAL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input int obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk(("scoreboard_underflow"), 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Launch a sweep: model the expected peak, queue expectations, run, then compare.
  task automatic run_sweep(input string name, input bit horiz, input bit both,
                           input int seq[SWEEP_STEPS]);
    int best, bpos, n;
    best = seq[0];
    bpos = 0;
    for (int i = 1; i < SWEEP_STEPS; i++)
      if (seq[i] > best + MARGIN) begin
        best = seq[i];
        bpos = i;
      end
    push_exp({name, "_cycles"}, SWEEP_STEPS * STEP_DIV);
    push_exp({name, "_max_pos"}, bpos);
    push_exp({name, "_max_val"}, best);
    push_exp({name, "_cnt_ru"}, (bpos != SWEEP_STEPS - 1) ? 1 : 0);
    if (both) push_exp({name, "_cnt_d_kept"}, 1);

    HS = horiz | both;
    VS = !horiz | both;
    n = 0;
    while ((horiz ? CNT_L : CNT_D) && n < BOUND) begin
      LIGHT = LIGHT_W'(seq[(n / STEP_DIV) % SWEEP_STEPS]);
      step();
      n++;
    end
    pop_chk(n);
    pop_chk(int'(MAX_POS));
    pop_chk(int'(MAX_VAL));
    pop_chk(int'(CNT_RU));
    if (both) pop_chk(int'(CNT_D));
    HS = 1'b0;
    VS = 1'b0;
    step();
  endtask

  task automatic run_return(input string name, input int steps);
    int n;
    push_exp({name, "_cycles"}, steps * STEP_DIV);
    MC = 1'b1;
    n = 0;
    while (CNT_RU && n < BOUND) begin
      step();
      n++;
    end
    pop_chk(n);
    MC = 1'b0;
    step();
  endtask

  int seq_a[SWEEP_STEPS] = '{5, 9, 30, 12, 30, 3, 1, 0};
  int seq_r[SWEEP_STEPS] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int seq_h[SWEEP_STEPS] = '{10, 12, 13, 9, 8, 7, 6, 5};

  initial begin
    repeat (3) step();
    chk("rst_cnt_l", CNT_L, 1);
    chk("rst_cnt_d", CNT_D, 1);
    chk("rst_cnt_ru", CNT_RU, 0);
    chk("rst_max_pos", MAX_POS, 0);
    chk("rst_max_val", MAX_VAL, 0);
    RST = 1'b0;
    step();

    run_sweep("hs", 1'b1, 1'b0, seq_a);
    chk("hs_cnt_l", CNT_L, 0);
    chk("hs_cnt_d_kept", CNT_D, 1);
    run_return("ret", SWEEP_STEPS - 1 - 2);

    run_sweep("vs_last", 1'b0, 1'b0, seq_r);
    chk("vs_cnt_d", CNT_D, 0);
    MC = 1'b1;
    repeat (3 * STEP_DIV) step();
    chk("mc_no_dec_ru", CNT_RU, 0);
    chk("mc_no_dec_pos", MAX_POS, SWEEP_STEPS - 1);
    MC = 1'b0;
    step();

    CNT_RST = 1'b1;
    step();
    CNT_RST = 1'b0;
    chk("rearm_cnt_l", CNT_L, 1);
    chk("rearm_cnt_d", CNT_D, 1);
    chk("rearm_max_pos", MAX_POS, 0);
    chk("rearm_max_val", MAX_VAL, 0);

    run_sweep("hyst_hsvs", 1'b1, 1'b1, seq_h);

    VS = 1'b1;
    repeat (3 * STEP_DIV + 2) step();
    RST = 1'b1;
    #1;
    chk("abort_cnt_ru", CNT_RU, 0);
    chk("abort_max_pos", MAX_POS, 0);
    chk("abort_max_val", MAX_VAL, 0);
    chk("abort_cnt_l", CNT_L, 1);
    chk("abort_cnt_d", CNT_D, 1);
    VS = 1'b0;
    step();
    RST = 1'b0;
    step();
    run_sweep("post_abort", 1'b0, 1'b0, seq_a);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
